// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int          DEF_DBITS       = 32;
  localparam int          DEF_INSTR_BYTES = 4;
  localparam logic [31:0] DEF_START_PC    = 32'h40;

  typedef struct packed {
    logic [DEF_DBITS-1:0] pc;
    logic [DEF_DBITS-1:0] instr;
  } fetch_entry_t;

  // Clears the sub-instruction offset bits; instrBytes must be a power of 2.
  function automatic logic [63:0] align_pc(input logic [63:0] addr, input int instrBytes);
    return addr & ~(64'(instrBytes) - 64'd1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage boundary: redirect in, imem request/response, decode-side queue head.
interface fetch_if #(parameter int DBITS = 32);

  logic             redirect;
  logic [DBITS-1:0] redirect_target;
  logic             imem_req;
  logic [DBITS-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [DBITS-1:0] imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [DBITS-1:0] out_instr;
  logic [DBITS-1:0] out_pc;
  logic [DBITS-1:0] out_pc_plus;

  modport master (
    input  redirect, redirect_target, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus
  );

  modport slave (
    output redirect, redirect_target, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order FIFO, push visible at head next cycle; flush beats push/pop.
// No backpressure of its own: the producer must not push while full.
module fetch_queue import fetch_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       pushData,
  output T                       headData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  rdPtr;
  logic [AW-1:0]  wrPtr;
  logic           doPush;
  logic           doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// PC generation + imem request issue + fetch queue; response-to-out_valid is 1 cycle.
// Requests throttle so queued + live in-flight never exceed FQ_DEPTH; decode stalls via out_ready.
module fetch_unit import fetch_pkg::*; #(
  parameter int               DBITS       = DEF_DBITS,
  parameter logic [DBITS-1:0] START_PC    = DBITS'(DEF_START_PC),
  parameter int               INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int               FQ_DEPTH    = 4
) (
  input logic      clk,
  input logic      reset,
  fetch_if.master  bus
);

  localparam int               CW   = $clog2(FQ_DEPTH) + 1;
  localparam logic [DBITS-1:0] STEP = DBITS'(INSTR_BYTES);

  typedef struct packed {
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] instr;
  } entry_t;

  logic [DBITS-1:0] pc;
  logic [DBITS-1:0] respPc;
  logic [DBITS-1:0] target;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    outstandingNext;
  logic [CW-1:0]    discardCnt;
  logic [CW-1:0]    qCount;
  logic [CW-1:0]    liveInFlight;
  logic [CW:0]      occupancy;
  logic             granted;
  logic             pushEn;
  logic             popEn;
  logic             qEmpty;
  logic             qFull;
  entry_t           pushEntry;
  entry_t           head;

  // Discarded responses are already doomed, so they do not reserve queue space.
  assign liveInFlight    = outstanding - discardCnt;
  assign occupancy       = {1'b0, qCount} + {1'b0, liveInFlight};
  assign bus.imem_req    = reset & ~qFull & (occupancy < (CW+1)'(FQ_DEPTH));
  assign bus.imem_addr   = pc;
  assign granted         = bus.imem_req & bus.imem_gnt;
  assign outstandingNext = outstanding + CW'(granted) - CW'(bus.imem_rvalid);
  assign target          = DBITS'(align_pc(64'(bus.redirect_target), INSTR_BYTES));

  assign pushEn    = bus.imem_rvalid & (discardCnt == '0) & ~bus.redirect;
  assign popEn     = bus.out_valid & bus.out_ready;
  assign pushEntry = '{pc: respPc, instr: bus.imem_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= START_PC;
      respPc      <= START_PC;
      outstanding <= '0;
      discardCnt  <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (bus.redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        pc         <= target;
        respPc     <= target;
        discardCnt <= outstandingNext;
      end else begin
        if (granted) pc <= pc + STEP;
        if (bus.imem_rvalid) begin
          if (discardCnt != '0) discardCnt <= discardCnt - CW'(1);
          else                  respPc     <= respPc + STEP;
        end
      end
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH), .T(entry_t)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (pushEn),
    .pop      (popEn),
    .flush    (bus.redirect),
    .pushData (pushEntry),
    .headData (head),
    .count    (qCount),
    .empty    (qEmpty),
    .full     (qFull)
  );

  assign bus.out_valid   = ~qEmpty;
  assign bus.out_instr   = head.instr;
  assign bus.out_pc      = head.pc;
  assign bus.out_pc_plus = head.pc + STEP;

  assert property (@(posedge clk) disable iff (!reset) bus.imem_rvalid |-> outstanding != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a path/epoch reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.DBITS(32)) bus ();
  fetch_if #(.DBITS(32)) bus2 ();

  fetch_unit #(.DBITS(32), .START_PC(32'h40), .INSTR_BYTES(4), .FQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  fetch_unit #(.DBITS(32), .START_PC(32'hFFFF_FFF8), .INSTR_BYTES(4), .FQ_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Memory side: every granted request, tagged with the fetch path it belongs to.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        memQ[$];
  logic [31:0] modelQ[$];
  logic [31:0] expReqPc;
  int          epoch;
  int          cycleNo = 0;
  int          maxLat  = 0;
  bit          rvEn    = 1'b1;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.redirect = 1'b0;  bus.redirect_target = '0; bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.out_ready = 1'b0;
    bus2.redirect = 1'b0; bus2.redirect_target = '0; bus2.imem_gnt = 1'b0;
    bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0; bus2.out_ready = 1'b0;
  endtask

  task automatic model_reset();
    memQ.delete();
    modelQ.delete();
    expReqPc = 32'h40;
    epoch    = 0;
  endtask

  // One clock cycle on the main DUT: drive, compare to model, advance model.
  task automatic cyc(input bit rd, input logic [31:0] tgt, input bit gnt, input bit rdy);
    int   live;
    bit   expReq, rv, grant, pop;
    req_t r;
    @(negedge clk);
    cycleNo++;
    live = 0;
    foreach (memQ[i]) if (memQ[i].epoch == epoch) live++;
    expReq = (modelQ.size() + live) < 4;
    rv     = rvEn && (memQ.size() > 0) && (memQ[0].due <= cycleNo);

    bus.redirect        = rd;
    bus.redirect_target = tgt;
    bus.imem_gnt        = gnt;
    bus.out_ready       = rdy;
    bus.imem_rvalid     = rv;
    bus.imem_rdata      = rv ? instrOf(memQ[0].addr) : $urandom;

    check("imem_req", 32'(bus.imem_req), 32'(expReq));
    if (expReq) check("imem_addr", bus.imem_addr, expReqPc);
    check("out_valid", 32'(bus.out_valid), 32'(modelQ.size() > 0));
    if (modelQ.size() > 0) begin
      check("out_pc", bus.out_pc, modelQ[0]);
      check("out_instr", bus.out_instr, instrOf(modelQ[0]));
      check("out_pc_plus", bus.out_pc_plus, modelQ[0] + 32'd4);
    end

    grant = expReq && gnt;
    pop   = (modelQ.size() > 0) && rdy;
    if (rv) r = memQ.pop_front();
    if (rd) begin
      modelQ.delete();
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (rv && r.epoch == epoch) modelQ.push_back(r.addr);
    end
    if (grant) begin
      memQ.push_back('{addr: expReqPc, epoch: epoch, due: cycleNo + 1 + int'($urandom_range(0, maxLat))});
      expReqPc += 32'd4;
    end
    if (rd) begin
      epoch++;
      expReqPc = tgt & ~32'h3;
    end
  endtask

  // Assert reset between edges, check outputs drop at once, then release after an edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_addr", bus.imem_addr, 32'h40);
    check("rst2_addr", bus2.imem_addr, 32'hFFFF_FFF8);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int          grants;
    bit          found;
    bit          pend;
    logic [31:0] pendAddr;
    logic [31:0] addrs[6];
    logic [31:0] pcs[6];
    logic [31:0] plus[6];
    logic [31:0] instrs[6];
    logic        vld[6];

    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", 32'(bus.imem_req), 32'h0);
    check("reset_valid", 32'(bus.out_valid), 32'h0);
    check("reset_addr", bus.imem_addr, 32'h40);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Streaming: fixed one-cycle memory latency, decode always ready.
    maxLat = 0; rvEn = 1'b1;
    cyc(0, 0, 1, 1);
    check("t1_addr0", bus.imem_addr, 32'h40);
    check("t1_req0", 32'(bus.imem_req), 32'h1);
    cyc(0, 0, 1, 1);
    check("t1_addr1", bus.imem_addr, 32'h44);
    check("t1_valid1", 32'(bus.out_valid), 32'h0);
    cyc(0, 0, 1, 1);
    check("t1_addr2", bus.imem_addr, 32'h48);
    check("t1_valid2", 32'(bus.out_valid), 32'h1);
    check("t1_pc2", bus.out_pc, 32'h40);
    check("t1_plus2", bus.out_pc_plus, 32'h44);
    repeat (6) cyc(0, 0, 1, 1);

    // Decode stalled: exactly FQ_DEPTH grants, then resume after pops.
    do_reset();
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0);
      if (bus.imem_req) grants++;
    end
    check("t2_grants", 32'(grants), 32'd4);
    check("t2_req_off", 32'(bus.imem_req), 32'h0);
    cyc(0, 0, 1, 1);
    check("t2_head", bus.out_pc, 32'h40);
    cyc(0, 0, 1, 1);
    check("t2_resume_req", 32'(bus.imem_req), 32'h1);
    check("t2_resume_addr", bus.imem_addr, 32'h50);
    repeat (8) cyc(0, 0, 1, 1);

    // Grant withheld: address must hold.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      check("t3_req", 32'(bus.imem_req), 32'h1);
      check("t3_addr", bus.imem_addr, 32'h40);
    end
    repeat (4) cyc(0, 0, 1, 1);

    // Redirect with three requests in flight.
    do_reset();
    rvEn = 1'b0;
    repeat (3) cyc(0, 0, 1, 1);
    cyc(1, 32'h103, 0, 1);
    cyc(0, 0, 0, 1);
    check("t4_addr", bus.imem_addr, 32'h100);
    check("t4_empty", 32'(bus.out_valid), 32'h0);
    rvEn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 1, 1);
      if (bus.out_valid) begin
        found = 1'b1;
        check("t4_first_pc", bus.out_pc, 32'h100);
      end
    end
    check("t4_seen", 32'(found), 32'h1);

    // Redirect coincident with grant, response and pop.
    do_reset();
    repeat (3) cyc(0, 0, 1, 0);
    cyc(1, 32'h200, 1, 1);
    cyc(0, 0, 0, 1);
    check("t5_addr", bus.imem_addr, 32'h200);
    check("t5_empty", 32'(bus.out_valid), 32'h0);
    repeat (10) cyc(0, 0, 1, 1);
    repeat (6) cyc(0, 0, 0, 1);
    rvEn = 1'b0;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0);
      if (bus.imem_req) grants++;
    end
    check("t5_full_credit", 32'(grants), 32'd4);

    // Randomized traffic with a reset in the middle of a burst.
    do_reset();
    maxLat = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rvEn = ($urandom % 4) != 0;
      cyc(($urandom % 20) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    // Address wrap on the second instance.
    do_reset();
    pend = 1'b0;
    pendAddr = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus2.imem_gnt    = 1'b1;
      bus2.out_ready   = 1'b1;
      bus2.imem_rvalid = pend;
      bus2.imem_rdata  = instrOf(pendAddr);
      addrs[i]  = bus2.imem_addr;
      vld[i]    = bus2.out_valid;
      pcs[i]    = bus2.out_pc;
      plus[i]   = bus2.out_pc_plus;
      instrs[i] = bus2.out_instr;
      pend      = bus2.imem_req;
      pendAddr  = bus2.imem_addr;
    end
    idle_inputs();
    check("wrap_addr0", addrs[0], 32'hFFFF_FFF8);
    check("wrap_addr1", addrs[1], 32'hFFFF_FFFC);
    check("wrap_addr2", addrs[2], 32'h0);
    check("wrap_addr3", addrs[3], 32'h4);
    check("wrap_valid1", 32'(vld[1]), 32'h0);
    check("wrap_valid2", 32'(vld[2]), 32'h1);
    check("wrap_pc2", pcs[2], 32'hFFFF_FFF8);
    check("wrap_plus3", plus[3], 32'h0);
    check("wrap_pc4", pcs[4], 32'h0);
    check("wrap_instr4", instrs[4], instrOf(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
